// File: rtl/imem_dmem_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the load/store unit.
// One transaction is in flight at a time. Data has priority, and a starvation counter bounds how long fetch can wait.
//
// state | meaning
// IDLE  | no request held; the winner is presented to memory combinationally
// REQ   | request shown to memory but not yet granted; owner and fields held in registers
// WAIT  | request granted; waiting for the response
module imem_dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_kill_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e            state_q;
    logic              own_fetch_q;
    logic              drop_q;
    logic [3:0]        starve_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              any_req;
    logic              fetch_win;
    logic              sel_we;
    logic [3:0]        sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              gnt_fetch;
    logic              gnt_data;
    logic              rsp_fetch;
    logic              rsp_data;

    always_comb begin
        any_req   = if_req_i | d_req_i;
        fetch_win = if_req_i & ((starve_q == LIMIT) | ~d_req_i);
        sel_we    = fetch_win ? 1'b0 : d_we_i;
        sel_be    = fetch_win ? 4'hF : d_be_i;
        sel_addr  = fetch_win ? if_addr_i : d_addr_i;
        sel_wdata = fetch_win ? 32'h0 : d_wdata_i;

        mem_req_o   = 1'b0;
        mem_we_o    = we_q;
        mem_be_o    = be_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        gnt_fetch   = 1'b0;
        gnt_data    = 1'b0;
        rsp_fetch   = 1'b0;
        rsp_data    = 1'b0;

        case (state_q)
            IDLE: begin
                mem_req_o   = any_req;
                mem_we_o    = sel_we;
                mem_be_o    = sel_be;
                mem_addr_o  = sel_addr;
                mem_wdata_o = sel_wdata;
                gnt_fetch   = mem_gnt_i & any_req & fetch_win;
                gnt_data    = mem_gnt_i & any_req & ~fetch_win;
            end
            REQ: begin
                mem_req_o = 1'b1;
                gnt_fetch = mem_gnt_i & own_fetch_q;
                gnt_data  = mem_gnt_i & ~own_fetch_q;
            end
            WAIT: begin
                // A kill arriving with the response still suppresses it.
                rsp_fetch = mem_rvalid_i & own_fetch_q & ~drop_q & ~if_kill_i;
                rsp_data  = mem_rvalid_i & ~own_fetch_q;
            end
            default: ;
        endcase

        if (rst) begin
            mem_req_o = 1'b0;
            gnt_fetch = 1'b0;
            gnt_data  = 1'b0;
            rsp_fetch = 1'b0;
            rsp_data  = 1'b0;
        end
    end

    assign if_gnt_o    = gnt_fetch;
    assign d_gnt_o     = gnt_data;
    assign if_rvalid_o = rsp_fetch;
    assign d_rvalid_o  = rsp_data;
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;
    assign busy_o      = (state_q != IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            own_fetch_q <= 1'b0;
            drop_q      <= 1'b0;
            starve_q    <= 4'd0;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        own_fetch_q <= fetch_win;
                        we_q        <= sel_we;
                        be_q        <= sel_be;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        state_q     <= mem_gnt_i ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (if_kill_i && own_fetch_q) drop_q <= 1'b1;
                    if (mem_gnt_i) state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                    end else if (if_kill_i && own_fetch_q) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (gnt_fetch) begin
                starve_q <= 4'd0;
            end else if (gnt_data && if_req_i && (starve_q != LIMIT)) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the DUT hands something over.
module tb_imem_dmem_arbiter;

    typedef struct packed {
        logic        rsp;
        logic        fetch;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0, if_kill_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        d_req_i = 1'b0, d_we_i = 1'b0;
    logic [3:0]  d_be_i = '0;
    logic [31:0] d_addr_i = '0, d_wdata_i = '0;
    logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
    logic [31:0] if_rdata_o, d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    // Memory side: either driven by hand, or an auto zero-wait responder.
    logic        auto_mode = 1'b0;
    logic        man_gnt = 1'b0, man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        auto_rsp_q = 1'b0;
    logic [31:0] auto_rdata_q = '0;

    assign mem_gnt_i    = auto_mode ? mem_req_o : man_gnt;
    assign mem_rvalid_i = auto_mode ? auto_rsp_q : man_rvalid;
    assign mem_rdata_i  = auto_mode ? auto_rdata_q : man_rdata;

    always @(posedge clk) begin
        auto_rsp_q <= mem_req_o && mem_gnt_i;
        if (mem_req_o && mem_gnt_i) auto_rdata_q <= {16'hA5A5, mem_addr_o[15:0]};
    end

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    txn_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_gnt(input logic fetch, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        sb.push_back('{rsp: 1'b0, fetch: fetch, we: we, be: be, addr: addr, data: wdata});
    endtask

    task automatic push_rsp(input logic fetch, input logic [31:0] rdata);
        sb.push_back('{rsp: 1'b1, fetch: fetch, we: 1'b0, be: 4'h0, addr: 32'h0, data: rdata});
    endtask

    task automatic pop_cmp(input string name, input txn_t act);
        txn_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected: got %h expected nothing (t=%0t)", name, act, $time);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h (t=%0t)", name, act, e, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        txn_t a;
        if (!rst) begin
            if (mem_req_o && mem_gnt_i) begin
                chk("gnt_onehot", 32'(if_gnt_o ^ d_gnt_o), 32'd1);
                a = '{rsp: 1'b0, fetch: if_gnt_o, we: mem_we_o, be: mem_be_o,
                      addr: mem_addr_o, data: mem_wdata_o};
                pop_cmp("grant", a);
            end
            if (if_rvalid_o || d_rvalid_o) begin
                a = '{rsp: 1'b1, fetch: if_rvalid_o, we: 1'b0, be: 4'h0, addr: 32'h0,
                      data: if_rvalid_o ? if_rdata_o : d_rdata_o};
                pop_cmp("response", a);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    function automatic logic [31:0] out_vec();
        return {26'd0, mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, busy_o};
    endfunction

    initial begin
        // Reset with both requesters and memory strobes active
        rst = 1'b1; if_req_i = 1'b1; d_req_i = 1'b1; man_gnt = 1'b1; man_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("reset_outputs", out_vec(), 32'd0);
            tick();
        end
        rst = 1'b0; if_req_i = 1'b0; d_req_i = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b1;
        at_neg();
        chk("stray_rvalid_idle", out_vec(), 32'd0);
        tick();
        man_rvalid = 1'b0;

        // Fetch alone, zero-wait memory
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h100; man_gnt = 1'b1;
        push_gnt(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        push_rsp(1'b1, 32'h0000_0013);
        at_neg();
        chk("fetch_gnt_c0", 32'(if_gnt_o), 32'd1);
        chk("fetch_busy_c0", 32'(busy_o), 32'd0);
        tick();
        if_req_i = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_0013;
        at_neg();
        chk("fetch_rvalid_c1", 32'(if_rvalid_o), 32'd1);
        chk("fetch_busy_c1", 32'(busy_o), 32'd1);
        tick();
        man_rvalid = 1'b0;
        at_neg();
        chk("fetch_busy_c2", 32'(busy_o), 32'd0);

        // Simultaneous write and fetch: data first, fetch two cycles later
        tick();
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 32'h2000; d_wdata_i = 32'hDEAD_BEEF;
        if_req_i = 1'b1; if_addr_i = 32'h180; man_gnt = 1'b1;
        push_gnt(1'b0, 1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF);
        push_rsp(1'b0, 32'h1111_1111);
        push_gnt(1'b1, 1'b0, 4'hF, 32'h180, 32'h0);
        push_rsp(1'b1, 32'h2222_2222);
        at_neg();
        chk("simul_d_gnt", 32'({d_gnt_o, if_gnt_o}), 32'b10);
        tick();
        d_req_i = 1'b0; d_we_i = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h1111_1111;
        at_neg();
        chk("simul_wait_noreq", 32'(mem_req_o), 32'd0);
        tick();
        man_rvalid = 1'b0; man_gnt = 1'b1;
        at_neg();
        chk("simul_fetch_addr", mem_addr_o, 32'h180);
        chk("simul_fetch_gnt", 32'({if_gnt_o, mem_we_o}), 32'b10);
        tick();
        if_req_i = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h2222_2222;
        tick();
        man_rvalid = 1'b0;

        // Kill while the fetch is held in REQ
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h240;
        at_neg();
        chk("kill_req_c0", 32'(mem_req_o), 32'd1);
        tick();
        if_kill_i = 1'b1; if_req_i = 1'b0; if_addr_i = 32'hBAD;
        at_neg();
        chk("kill_hold_addr_c1", mem_addr_o, 32'h240);
        chk("kill_hold_req_c1", 32'(mem_req_o), 32'd1);
        tick();
        if_kill_i = 1'b0;
        at_neg();
        chk("kill_hold_addr_c2", mem_addr_o, 32'h240);
        tick();
        man_gnt = 1'b1;
        push_gnt(1'b1, 1'b0, 4'hF, 32'h240, 32'h0);
        at_neg();
        chk("kill_late_gnt", 32'(if_gnt_o), 32'd1);
        tick();
        man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h3333_3333;
        at_neg();
        chk("kill_swallow", 32'(if_rvalid_o), 32'd0);
        tick();
        man_rvalid = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h2004; d_wdata_i = 32'h0; man_gnt = 1'b1;
        push_gnt(1'b0, 1'b0, 4'hF, 32'h2004, 32'h0);
        push_rsp(1'b0, 32'h4444_4444);
        at_neg();
        chk("post_kill_d_gnt", 32'(d_gnt_o), 32'd1);
        tick();
        d_req_i = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h4444_4444;
        at_neg();
        chk("post_kill_d_rvalid", 32'(d_rvalid_o), 32'd1);
        tick();
        man_rvalid = 1'b0;

        // Kill on the response cycle
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h300; man_gnt = 1'b1;
        push_gnt(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        tick();
        if_req_i = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h5555_5555; if_kill_i = 1'b1;
        at_neg();
        chk("kill_same_cycle", 32'(if_rvalid_o), 32'd0);
        tick();
        if_kill_i = 1'b0; man_rvalid = 1'b0;
        at_neg();
        chk("kill_same_idle", 32'(busy_o), 32'd0);

        // Reset while waiting; the late response is stale
        tick();
        d_req_i = 1'b1; d_addr_i = 32'h2008; man_gnt = 1'b1;
        push_gnt(1'b0, 1'b0, 4'hF, 32'h2008, 32'h0);
        tick();
        d_req_i = 1'b0; man_gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h6666_6666;
        at_neg();
        chk("rst_wait_late_rsp", 32'({d_rvalid_o, busy_o}), 32'd0);
        tick();
        man_rvalid = 1'b0;

        // Starvation: 4 data grants, 1 fetch grant, then 4 data grants again
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        auto_mode = 1'b1;
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h3000; d_wdata_i = 32'h0;
        if_req_i = 1'b1; if_addr_i = 32'h400;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) begin
                push_gnt(1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
                push_rsp(1'b1, 32'hA5A5_0400);
            end else begin
                push_gnt(1'b0, 1'b0, 4'hF, 32'h3000, 32'h0);
                push_rsp(1'b0, 32'hA5A5_3000);
            end
        end
        repeat (17) tick();
        d_req_i = 1'b0; if_req_i = 1'b0;
        tick();
        auto_mode = 1'b0;
        repeat (2) tick();

        at_neg();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
